ram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port program/data RAM of the 8-bit CPU. It shares the RAM between the CPU memory path (fetch and execute accesses) and a host port used for program load and debug readback. It accepts one request at a time, drives the RAM address, data, read-enable and write-enable lines from registers, and returns read data with a fixed latency.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_if.sv | 32 +++
 rtl/ram_arbiter_arb_pick.sv | 26 ++
 rtl/ram_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the CPU port, host port and RAM-side signals of the arbiter.
interface ram_arbiter_if
    import mem_arb_pkg::*;
    #(parameter int AW = DEF_AW, parameter int DW = DEF_DW) ();

    logic          cpu_req, host_req;
    logic          cpu_we, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, host_gnt;
    logic          cpu_rvalid, host_rvalid;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_rden, ram_wren;
    logic [DW-1:0] ram_q;
    logic          busy;

    modport slave (
        input  cpu_req, host_req, cpu_we, host_we, cpu_addr, host_addr,
               cpu_wdata, host_wdata, ram_q,
        output cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata,
               ram_addr, ram_data, ram_rden, ram_wren, busy
    );

    modport master (
        output cpu_req, host_req, cpu_we, host_we, cpu_addr, host_addr,
               cpu_wdata, host_wdata, ram_q,
        input  cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata,
               ram_addr, ram_data, ram_rden, ram_wren, busy
    );
endinterface

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational winner selector. ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise the CPU has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic host_req,
    input  logic last_owner,
    output logic winner,
    output logic any
);
    assign any = cpu_req | host_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port that did not own the previous access wins.
    always_comb begin
        winner = OWN_CPU;
        if (cpu_req && host_req) winner = ~last_owner;
        else if (host_req)       winner = OWN_HOST;
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign winner = (cpu_req || !host_req) ? OWN_CPU : OWN_HOST;
`endif
endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port CPU RAM.
// ARB_ROUND_ROBIN_EN enables the last-owner flag and round-robin arbitration.
module ram_arbiter
    import mem_arb_pkg::*;
    #(parameter int AW = DEF_AW, parameter int DW = DEF_DW)
(
    input  logic           clk,
    input  logic           rst,
    ram_arbiter_if.slave   bus
);
    state_e        state_q, state_d;
    logic          own_q, own_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_q, ram_data_d;
    logic          rden_q, rden_d, wren_q, wren_d;
    logic          cpu_gnt_q, cpu_gnt_d, host_gnt_q, host_gnt_d;
    logic          cpu_rvalid_q, cpu_rvalid_d, host_rvalid_q, host_rvalid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;
    logic          winner, any, last_owner;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_d     = (state_q == ST_IDLE && any) ? winner : last_q;
    assign last_owner = last_q;
`else
    assign last_owner = OWN_HOST;
`endif

    arb_pick u_pick (
        .cpu_req    (bus.cpu_req),
        .host_req   (bus.host_req),
        .last_owner (last_owner),
        .winner     (winner),
        .any        (any)
    );

    always_comb begin
        state_d       = state_q;
        own_d         = own_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        rden_d        = 1'b0;
        wren_d        = 1'b0;
        cpu_gnt_d     = 1'b0;
        host_gnt_d    = 1'b0;
        cpu_rvalid_d  = 1'b0;
        host_rvalid_d = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        host_rdata_d  = host_rdata_q;
        case (state_q)
            ST_IDLE: begin
                // RAM strobes and gnt are set up here so they are registered in ACCESS
                if (any) begin
                    state_d = ST_ACCESS;
                    own_d   = winner;
                    if (winner == OWN_HOST) begin
                        ram_addr_d = bus.host_addr;
                        ram_data_d = bus.host_wdata;
                        wren_d     = bus.host_we;
                        host_gnt_d = 1'b1;
                    end else begin
                        ram_addr_d = bus.cpu_addr;
                        ram_data_d = bus.cpu_wdata;
                        wren_d     = bus.cpu_we;
                        cpu_gnt_d  = 1'b1;
                    end
                    rden_d = ~wren_d;
                end
            end
            ST_ACCESS: state_d = wren_q ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                state_d = ST_IDLE;
                if (own_q == OWN_HOST) begin
                    host_rdata_d  = bus.ram_q;
                    host_rvalid_d = 1'b1;
                end else begin
                    cpu_rdata_d  = bus.ram_q;
                    cpu_rvalid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            own_q         <= OWN_HOST;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            rden_q        <= 1'b0;
            wren_q        <= 1'b0;
            cpu_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q        <= OWN_HOST;
`endif
        end else begin
            state_q       <= state_d;
            own_q         <= own_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            rden_q        <= rden_d;
            wren_q        <= wren_d;
            cpu_gnt_q     <= cpu_gnt_d;
            host_gnt_q    <= host_gnt_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            cpu_rdata_q   <= cpu_rdata_d;
            host_rdata_q  <= host_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q        <= last_d;
`endif
        end
    end

    assign bus.cpu_gnt     = cpu_gnt_q;
    assign bus.host_gnt    = host_gnt_q;
    assign bus.cpu_rvalid  = cpu_rvalid_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_rden    = rden_q;
    assign bus.ram_wren    = wren_q;
    assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed + random bench for ram_arbiter against a transaction-level memory model.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(8), .DW(8)) bus ();
    ram_arbiter #(.AW(8), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    // behavioural single-port RAM: address captured on the edge, data one cycle later
    logic [7:0] ram_mem [256];
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_data;
        if (bus.ram_rden) bus.ram_q <= ram_mem[bus.ram_addr];
    end

    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata [2];
    int last_own;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p != 0) ? bus.host_gnt : bus.cpu_gnt;
    endfunction
    function automatic logic rv_of(input int p);
        return (p != 0) ? bus.host_rvalid : bus.cpu_rvalid;
    endfunction
    function automatic logic [7:0] rd_of(input int p);
        return (p != 0) ? bus.host_rdata : bus.cpu_rdata;
    endfunction

    // spec rule: round-robin favours the non-previous owner on a tie, else CPU first
    function automatic int pick(input bit c, input bit h);
`ifdef ARB_ROUND_ROBIN_EN
        if (c && h) return 1 - last_own;
`endif
        return c ? 0 : 1;
    endfunction

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end else begin
            bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"}, {bus.cpu_gnt, bus.host_gnt, bus.cpu_rvalid, bus.host_rvalid,
                                bus.ram_rden, bus.ram_wren, bus.busy}, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_quiet(tag);
        chk({tag, "_regs"}, {bus.ram_addr, bus.ram_data, bus.cpu_rdata, bus.host_rdata}, 0);
    endtask

    task automatic model_reset();
        last_own = 1;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
    endtask

    // issue one access from IDLE (called at a negedge) and check its full timeline
    task automatic do_access(input int p, input bit we, input logic [7:0] a,
                             input logic [7:0] d, input string tag, output int gcyc);
        int o;
        o = 1 - p;
        drive(p, 1'b1, we, a, d);
        @(negedge clk);
        gcyc = cyc;
        chk({tag, "_gnt"}, gnt_of(p), 1);
        chk({tag, "_other_gnt"}, gnt_of(o), 0);
        chk({tag, "_wren_rden"}, {bus.ram_wren, bus.ram_rden}, we ? 2'b10 : 2'b01);
        chk({tag, "_addr"}, bus.ram_addr, a);
        if (we) chk({tag, "_data"}, bus.ram_data, d);
        last_own = p;
        drive(p, 1'b0, we, a, d);
        @(negedge clk);
        chk({tag, "_gnt_pulse"}, gnt_of(p), 0);
        chk({tag, "_strobe_off"}, {bus.ram_wren, bus.ram_rden}, 0);
        chk({tag, "_addr_hold"}, bus.ram_addr, a);
        if (we) begin
            ref_mem[a] = d;
            chk({tag, "_busy_w"}, bus.busy, 0);
        end else begin
            chk({tag, "_busy_wait"}, bus.busy, 1);
            chk({tag, "_early_rv"}, rv_of(p), 0);
            @(negedge clk);
            exp_rdata[p] = ref_mem[a];
            chk({tag, "_rvalid"}, rv_of(p), 1);
            chk({tag, "_rdata"}, rd_of(p), exp_rdata[p]);
            chk({tag, "_other_rv"}, rv_of(o), 0);
            chk({tag, "_other_rdata"}, rd_of(o), exp_rdata[o]);
            chk({tag, "_busy_r"}, bus.busy, 0);
        end
    endtask

    int gc, prev_gc, grants, waitc, exp_w, rp;
    bit rwe;
    logic [7:0] ra, rd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        model_reset();

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            drive(1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
            chk_reset_outs("reset_hold");
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("post_reset_idle");
        end

        // CPU write then read
        do_access(0, 1'b1, 8'h10, 8'hA5, "cpu_wr", gc);
        do_access(0, 1'b0, 8'h10, 8'h00, "cpu_rd", gc);
        chk("cpu_rd_const", bus.cpu_rdata, 8'hA5);

        // host program load, back-to-back every 2 cycles
        prev_gc = 0;
        for (int i = 0; i < 16; i++) begin
            do_access(1, 1'b1, 8'(i), 8'(i) ^ 8'h3C, "host_load", gc);
            if (i > 0) chk("host_load_spacing", gc - prev_gc, 2);
            prev_gc = gc;
        end
        do_access(0, 1'b0, 8'h0F, 8'h00, "cpu_readback", gc);
        chk("cpu_readback_const", bus.cpu_rdata, 8'h33);

        // read isolation
        do_access(0, 1'b1, 8'h30, 8'h55, "iso_cpu_wr", gc);
        do_access(0, 1'b0, 8'h30, 8'h00, "iso_cpu_rd", gc);
        do_access(1, 1'b1, 8'h20, 8'h77, "iso_host_wr", gc);
        do_access(1, 1'b0, 8'h20, 8'h00, "iso_host_rd", gc);
        chk("iso_host_rdata", bus.host_rdata, 8'h77);
        chk("iso_cpu_rdata", bus.cpu_rdata, 8'h55);
        chk("iso_cpu_rvalid", bus.cpu_rvalid, 0);

        // contention: both requests held
        drive(0, 1'b1, 1'b1, 8'h40, 8'hC1);
        drive(1, 1'b1, 1'b1, 8'h41, 8'hD2);
        grants = 0; waitc = 0; prev_gc = 0;
        while (grants < 10 && waitc < 60) begin
            @(negedge clk);
            waitc++;
            if (bus.cpu_gnt || bus.host_gnt) begin
                exp_w = pick(1'b1, 1'b1);
                chk("cont_single_gnt", bus.cpu_gnt & bus.host_gnt, 0);
                chk("cont_winner", {bus.cpu_gnt, bus.host_gnt}, (exp_w != 0) ? 2'b01 : 2'b10);
                if (grants > 0) chk("cont_spacing", cyc - prev_gc, 2);
                prev_gc = cyc;
                if (exp_w != 0) ref_mem[8'h41] = 8'hD2; else ref_mem[8'h40] = 8'hC1;
                last_own = exp_w;
                grants++;
                if (grants == 10) bus.cpu_req = 1'b0;
            end
        end
        chk("cont_grants", grants, 10);
        @(negedge clk);
        chk("cont_gap", {bus.cpu_gnt, bus.host_gnt}, 0);
        @(negedge clk);
        chk("cont_host_after", {bus.cpu_gnt, bus.host_gnt}, 2'b01);
        last_own = 1;
        ref_mem[8'h41] = 8'hD2;
        bus.host_req = 1'b0;
        @(negedge clk);
        do_access(0, 1'b0, 8'h40, 8'h00, "cont_rd_cpu", gc);
        do_access(1, 1'b0, 8'h41, 8'h00, "cont_rd_host", gc);

        // reset during ACCESS of a write: must not reach the RAM
        drive(0, 1'b1, 1'b1, 8'hEE, ~ref_mem[8'hEE]);
        drive(1, 1'($urandom), 1'b1, 8'($urandom), 8'($urandom));
        @(negedge clk);
        chk("rst_acc_pre_wren", bus.ram_wren, 1);
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_in_access");
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("rst_acc_release");
        end

        // abort a CPU read in WAIT
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        chk("abort_gnt", bus.cpu_gnt, 1);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_in_wait", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk_reset_outs("abort_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rvalid", bus.cpu_rvalid, 0);
            chk("abort_rdata_zero", bus.cpu_rdata, 0);
        end
        do_access(0, 1'b0, 8'hEE, 8'h00, "abort_next_rd", gc);

        // random single-port traffic
        for (int i = 0; i < 40; i++) begin
            rp  = int'($urandom_range(0, 1));
            rwe = 1'($urandom);
            ra  = 8'($urandom_range(0, 63));
            rd  = 8'($urandom);
            do_access(rp, rwe, ra, rd, "rand", gc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
